mem_bus_arbiter: RTL and testbench

// - Shares one single-port memory bus between the core's instruction fetch and its data load/store.
// - Sits between the core (PC/instruction path, memload/writeData path) and the RAM.
// - Grants data accesses ahead of fetch and stalls the core while any access is outstanding.
// - Returns one-cycle acks and holds the captured read data until the next ack.

---
 rtl/mem_bus_arbiter_pkg.sv | 15 +
 rtl/mem_bus_arbiter_timer.sv | 33 +++
 rtl/mem_bus_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the instruction/data memory bus arbiter.
package arb_pkg;

    typedef enum logic [2:0] {IDLE, FETCH, DREAD, DWRITE, DONE} arb_state_t;
    typedef enum logic [1:0] {G_NONE, G_INSTR, G_DATA} grant_t;

    localparam int unsigned DEFAULT_TIMEOUT = 16;

    function automatic int unsigned wait_width(input int unsigned timeout);
        return $clog2(timeout + 1);
    endfunction

    localparam int unsigned WAIT_W = $clog2(DEFAULT_TIMEOUT + 1);

endpackage

// File: rtl/mem_bus_arbiter_timer.sv
// Saturating bus wait counter: clear/enable with started and timeout flags.
module bus_wait_timer
    import arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic nrst,
    input  logic clr,
    input  logic en,
    output logic started,
    output logic expired
);

    localparam int unsigned CntW = wait_width(TIMEOUT);
    localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != Limit)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign started = (cnt_q != '0);
    assign expired = (cnt_q == Limit);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-port memory bus arbiter: data accesses win over fetch, one access in flight.
module mem_bus_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_rd_req,
    input  logic              d_wr_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              bus_err,
    output logic              cpu_stall,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_busy
);

    arb_state_t state_q;
    grant_t     grant;
    logic       timer_clr;
    logic       started;
    logic       expired;
    logic       finish;

    always_comb begin
        grant = G_NONE;
        if (d_wr_req || d_rd_req) begin
            grant = G_DATA;
        end else if (i_req) begin
            grant = G_INSTR;
        end
    end

    assign timer_clr = (state_q == IDLE) || (state_q == DONE);
    // The first bus cycle never completes; after that busy-low or timeout ends it.
    assign finish    = (started && !mem_busy) || expired;

    bus_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .nrst    (nrst),
        .clr     (timer_clr),
        .en      (!timer_clr),
        .started (started),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= IDLE;
            i_rdata   <= '0;
            i_ack     <= 1'b0;
            d_rdata   <= '0;
            d_ack     <= 1'b0;
            bus_err   <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    case (grant)
                        G_DATA: begin
                            mem_addr <= d_addr;
                            if (d_wr_req) begin
                                mem_write <= 1'b1;
                                mem_wdata <= d_wdata;
                                state_q   <= DWRITE;
                            end else begin
                                mem_read <= 1'b1;
                                state_q  <= DREAD;
                            end
                        end
                        G_INSTR: begin
                            mem_addr <= i_addr;
                            mem_read <= 1'b1;
                            state_q  <= FETCH;
                        end
                        default: ;
                    endcase
                end
                FETCH, DREAD, DWRITE: begin
                    if (finish) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        bus_err   <= mem_busy;
                        state_q   <= DONE;
                        // A timed-out read returns zero rather than stale bus data.
                        if (state_q == FETCH) begin
                            i_ack   <= 1'b1;
                            i_rdata <= mem_busy ? '0 : mem_rdata;
                        end else begin
                            d_ack <= 1'b1;
                            if (state_q == DREAD) begin
                                d_rdata <= mem_busy ? '0 : mem_rdata;
                            end
                        end
                    end
                end
                DONE: begin
                    i_ack   <= 1'b0;
                    d_ack   <= 1'b0;
                    bus_err <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cpu_stall = (i_req | d_rd_req | d_wr_req) & ~(i_ack | d_ack);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter with a behavioural memory and random traffic.
module tb_mem_bus_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int TO = 16;

    logic          clk;
    logic          nrst;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_ack;
    logic          d_rd_req;
    logic          d_wr_req;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ack;
    logic          bus_err;
    logic          cpu_stall;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_busy;

    mem_bus_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_ack     (i_ack),
        .d_rd_req  (d_rd_req),
        .d_wr_req  (d_wr_req),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ack     (d_ack),
        .bus_err   (bus_err),
        .cpu_stall (cpu_stall),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_busy  (mem_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pattern(input logic [7:0] idx);
        if (idx == 8'd1) return 32'h3E80_0093;
        return {idx, ~idx, idx ^ 8'h5A, 8'hC3};
    endfunction

    // Behavioural memory: busy for the first busy_len cycles of each strobe.
    int          busy_len = 1;
    int          k = 0;
    logic [31:0] dev_mem     [256] = '{default: 32'h0};
    logic        dev_written [256] = '{default: 1'b0};
    logic [7:0]  ri;

    assign ri        = mem_addr[9:2];
    assign mem_busy  = (mem_read | mem_write) && (k < busy_len);
    assign mem_rdata = dev_written[ri] ? dev_mem[ri] : pattern(ri);

    always @(posedge clk) begin
        k <= (mem_read | mem_write) ? k + 1 : 0;
        if (mem_write && !mem_busy && k >= 1) begin
            dev_mem[ri]     <= mem_wdata;
            dev_written[ri] <= 1'b1;
        end
    end

    // Reference model state and scoreboard.
    typedef struct packed {
        logic        is_data;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ref_mem [256];
    logic [31:0] last_d = 32'h0;
    exp_t        m;

    always @(negedge clk) begin
        if (nrst && (i_ack || d_ack)) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", {30'd0, i_ack, d_ack}, 32'd0);
            end else begin
                m = sb.pop_front();
                check("ack_both", {31'd0, i_ack & d_ack}, 32'd0);
                check("ack_src", {31'd0, d_ack}, {31'd0, m.is_data});
                check("rdata", m.is_data ? d_rdata : i_rdata, m.rdata);
                check("bus_err", {31'd0, bus_err}, {31'd0, m.err});
                check("stall_in_ack", {31'd0, cpu_stall}, 32'd0);
            end
        end
    end

    // Length of the strobe-low run preceding the latest strobe rise.
    int low_run  = 0;
    int last_gap = -1;
    logic prev_strobe = 1'b0;

    always @(posedge clk) begin
        #1;
        if (!(mem_read | mem_write)) begin
            low_run = low_run + 1;
        end else begin
            if (!prev_strobe) last_gap = low_run;
            low_run = 0;
        end
        prev_strobe = mem_read | mem_write;
    end

    // kind: 0 fetch, 1 load, 2 store, 3 store with load also raised.
    task automatic do_access(input int kind, input int idx, input logic [31:0] wdata,
                             input int blen);
        logic [31:0] addr;
        exp_t        e;
        int          kc;
        int          n;
        bit          got;
        bit          rd_seen;
        addr = {22'd0, idx[7:0], 2'b00};
        @(negedge clk);
        busy_len = blen;
        e.err = (blen > TO);
        kc = e.err ? TO : ((blen < 1) ? 1 : blen);
        if (kind == 0) begin
            i_req = 1'b1;
            i_addr = addr;
            e.is_data = 1'b0;
            e.rdata = e.err ? 32'h0 : ref_mem[idx];
        end else if (kind == 1) begin
            d_rd_req = 1'b1;
            d_addr = addr;
            e.is_data = 1'b1;
            e.rdata = e.err ? 32'h0 : ref_mem[idx];
            last_d = e.rdata;
        end else begin
            d_wr_req = 1'b1;
            d_rd_req = (kind == 3);
            d_addr = addr;
            d_wdata = wdata;
            e.is_data = 1'b1;
            e.rdata = last_d;
            if (!e.err) ref_mem[idx] = wdata;
        end
        sb.push_back(e);
        got = 0;
        rd_seen = 0;
        n = 0;
        while (!got && n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) begin
                check("strobe", {30'd0, mem_read, mem_write}, (kind <= 1) ? 32'd2 : 32'd1);
                check("mem_addr", mem_addr, addr);
                check("stall_busy", {31'd0, cpu_stall}, 32'd1);
                if (kind >= 2) check("mem_wdata", mem_wdata, wdata);
            end
            if (kind >= 2 && mem_read) rd_seen = 1;
            if (i_ack || d_ack) got = 1;
        end
        check("latency", n, kc + 2);
        if (kind >= 2) check("no_read_on_write", {31'd0, rd_seen}, 32'd0);
        @(negedge clk);
        i_req = 1'b0;
        d_rd_req = 1'b0;
        d_wr_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string name);
        check(name, {26'd0, i_ack, d_ack, bus_err, cpu_stall, mem_read, mem_write}, 32'd0);
        check({name, "_rdata"}, i_rdata | d_rdata, 32'd0);
        check({name, "_bus"}, mem_addr | mem_wdata, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int ri_idx;
        int blen;
        for (int i = 0; i < 256; i++) ref_mem[i] = pattern(8'(i));
        nrst = 1'b0;
        i_req = 1'b0;
        d_rd_req = 1'b0;
        d_wr_req = 1'b0;
        i_addr = '0;
        d_addr = '0;
        d_wdata = '0;

        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        nrst = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("post_reset");

        do_access(0, 1, 32'h0, 1);

        // Load and fetch raised together: load first, then fetch.
        @(negedge clk);
        busy_len = 3;
        i_req = 1'b1;
        i_addr = 32'h0000_0028;
        d_rd_req = 1'b1;
        d_addr = 32'h0000_0100;
        last_d = ref_mem[64];
        sb.push_back('{is_data: 1'b1, err: 1'b0, rdata: ref_mem[64]});
        sb.push_back('{is_data: 1'b0, err: 1'b0, rdata: ref_mem[10]});
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!d_ack && n < 40);
        check("pair_load_latency", n, 5);
        @(negedge clk);
        d_rd_req = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!i_ack && n < 40);
        check("pair_fetch_latency", n, 6);
        // DONE plus the arbitration cycle separate the two strobes.
        check("pair_gap", last_gap, 2);
        @(negedge clk);
        i_req = 1'b0;
        @(negedge clk);

        do_access(3, 128, 32'hDEAD_BEEF, 2);
        do_access(1, 128, 32'h0, 0);
        do_access(0, 7, 32'h0, 1000);
        do_access(1, 9, 32'h0, 17);
        do_access(1, 9, 32'h0, 16);

        // Reset during a load stuck on busy.
        @(negedge clk);
        busy_len = 1000;
        d_rd_req = 1'b1;
        d_addr = 32'h0000_0040;
        repeat (4) @(posedge clk);
        #2;
        check("rst_mid_strobe_before", {31'd0, mem_read}, 32'd1);
        nrst = 1'b0;
        #1;
        check("rst_mid_strobe_drop", {31'd0, mem_read}, 32'd0);
        d_rd_req = 1'b0;
        last_d = 32'h0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_outputs("rst_mid_after");
        do_access(1, 16, 32'h0, 2);

        for (int t = 0; t < 40; t++) begin
            ri_idx = int'($urandom_range(0, 255));
            blen = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 5));
            do_access(int'($urandom_range(0, 3)), ri_idx, $urandom, blen);
        end

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
